// File: rtl/lcd_bus_responder_if.sv
// Parallel HD44780-style bus between an LCD controller (master) and the bus responder (slave).
// The strobe side carries DB/RS/E/RW. The status side carries decoded display state and event pulses.
interface lcd_bus_responder_if;
    logic [7:0]   DB;
    logic         RS;
    logic         E;
    logic         RW;
    logic [127:0] line_a;
    logic [127:0] line_b;
    logic         disp_on;
    logic [6:0]   ddram_addr;
    logic         busy;
    logic         wr_strobe;
    logic         cmd_err;
    logic         timing_err;

    modport master (
        output DB, RS, E, RW,
        input  line_a, line_b, disp_on, ddram_addr, busy, wr_strobe, cmd_err, timing_err
    );

    modport slave (
        input  DB, RS, E, RW,
        output line_a, line_b, disp_on, ddram_addr, busy, wr_strobe, cmd_err, timing_err
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// Device-side model of a KS0066/HD44780 8-bit bus: captures E strobes, decodes writes into a
// 2x40 DDRAM and exposes the 16 visible columns of both lines.
module lcd_bus_responder #(
    parameter int INS_BUSY   = 10,
    parameter int DATA_BUSY  = 10,
    parameter int CLEAR_BUSY = 160,
    parameter int E_MIN_HIGH = 2
) (
    input  logic               mclk,
    input  logic               rst,
    lcd_bus_responder_if.slave bus
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_HIGH   = 2'd1;
    localparam logic [1:0]  ST_COMMIT = 2'd2;
    localparam logic [15:0] INS_CYC   = 16'(INS_BUSY);
    localparam logic [15:0] DATA_CYC  = 16'(DATA_BUSY);
    localparam logic [15:0] CLEAR_CYC = 16'(CLEAR_BUSY);
    localparam logic [7:0]  MIN_HIGH  = 8'(E_MIN_HIGH);

    logic [1:0]   state_q, state_d;
    logic [7:0]   highCnt_q, highCnt_d;
    logic [7:0]   capDb_q, capDb_d;
    logic         capRs_q, capRs_d;
    logic         capRw_q, capRw_d;
    logic         riseBusy_q, riseBusy_d;
    logic [15:0]  busyCnt_q, busyCnt_d;
    logic [6:0]   addr_q, addr_d;
    logic         incMode_q, incMode_d;
    logic         dispOn_q, dispOn_d;
    logic         cgram_q, cgram_d;
    logic         wrStrobe_q, wrStrobe_d;
    logic         cmdErr_q, cmdErr_d;
    logic         timingErr_q, timingErr_d;
    logic         memWe, memClear;
    logic [7:0]   ddram_q [0:79];
    logic [127:0] lineA, lineB;

    // The two 40-byte lines form one 80-cell ring for cursor stepping.
    function automatic logic [6:0] stepAddr(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic [6:0] ramIndex(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    always_comb begin
        state_d     = state_q;
        highCnt_d   = highCnt_q;
        capDb_d     = capDb_q;
        capRs_d     = capRs_q;
        capRw_d     = capRw_q;
        riseBusy_d  = riseBusy_q;
        busyCnt_d   = (busyCnt_q != 16'd0) ? busyCnt_q - 16'd1 : 16'd0;
        addr_d      = addr_q;
        incMode_d   = incMode_q;
        dispOn_d    = dispOn_q;
        cgram_d     = cgram_q;
        wrStrobe_d  = 1'b0;
        cmdErr_d    = 1'b0;
        timingErr_d = 1'b0;
        memWe       = 1'b0;
        memClear    = 1'b0;

        if (bus.E) begin
            capDb_d = bus.DB;
            capRs_d = bus.RS;
            capRw_d = bus.RW;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.E) begin
                    state_d    = ST_HIGH;
                    highCnt_d  = 8'd1;
                    riseBusy_d = (busyCnt_q != 16'd0);
                end
            end
            ST_HIGH: begin
                if (bus.E) begin
                    if (highCnt_q < MIN_HIGH) highCnt_d = highCnt_q + 8'd1;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (riseBusy_q || (highCnt_q < MIN_HIGH)) begin
                    timingErr_d = 1'b1;
                end else if (capRw_q) begin
                    cmdErr_d = 1'b1;
                end else if (capRs_q) begin
                    wrStrobe_d = 1'b1;
                    busyCnt_d  = DATA_CYC;
                    if (!cgram_q) begin
                        memWe  = 1'b1;
                        addr_d = stepAddr(addr_q, incMode_q);
                    end
                end else begin
                    // Instruction decode: the highest set bit selects the command.
                    busyCnt_d = INS_CYC;
                    if (capDb_q[7]) begin
                        cgram_d = 1'b0;
                        if ((capDb_q[6:0] <= 7'h27) ||
                            ((capDb_q[6:0] >= 7'h40) && (capDb_q[6:0] <= 7'h67)))
                            addr_d = capDb_q[6:0];
                        else
                            cmdErr_d = 1'b1;
                    end else if (capDb_q[6]) begin
                        cgram_d = 1'b1;
                    end else if (capDb_q[5]) begin
                        if (!capDb_q[4]) cmdErr_d = 1'b1;
                    end else if (capDb_q[4]) begin
                        if (!capDb_q[3]) addr_d = stepAddr(addr_q, capDb_q[2]);
                    end else if (capDb_q[3]) begin
                        dispOn_d = capDb_q[2];
                    end else if (capDb_q[2]) begin
                        incMode_d = capDb_q[1];
                    end else if (capDb_q[1]) begin
                        addr_d    = 7'h00;
                        busyCnt_d = CLEAR_CYC;
                    end else if (capDb_q[0]) begin
                        memClear  = 1'b1;
                        addr_d    = 7'h00;
                        incMode_d = 1'b1;
                        busyCnt_d = CLEAR_CYC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            highCnt_q   <= 8'd0;
            capDb_q     <= 8'd0;
            capRs_q     <= 1'b0;
            capRw_q     <= 1'b0;
            riseBusy_q  <= 1'b0;
            busyCnt_q   <= 16'd0;
            addr_q      <= 7'h00;
            incMode_q   <= 1'b1;
            dispOn_q    <= 1'b0;
            cgram_q     <= 1'b0;
            wrStrobe_q  <= 1'b0;
            cmdErr_q    <= 1'b0;
            timingErr_q <= 1'b0;
            for (int i = 0; i < 80; i++) ddram_q[i] <= 8'h20;
        end else begin
            state_q     <= state_d;
            highCnt_q   <= highCnt_d;
            capDb_q     <= capDb_d;
            capRs_q     <= capRs_d;
            capRw_q     <= capRw_d;
            riseBusy_q  <= riseBusy_d;
            busyCnt_q   <= busyCnt_d;
            addr_q      <= addr_d;
            incMode_q   <= incMode_d;
            dispOn_q    <= dispOn_d;
            cgram_q     <= cgram_d;
            wrStrobe_q  <= wrStrobe_d;
            cmdErr_q    <= cmdErr_d;
            timingErr_q <= timingErr_d;
            if (memClear) begin
                for (int i = 0; i < 80; i++) ddram_q[i] <= 8'h20;
            end else if (memWe) begin
                ddram_q[ramIndex(addr_q)] <= capDb_q;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lineA[8*i +: 8] = ddram_q[i];
            lineB[8*i +: 8] = ddram_q[40 + i];
        end
    end

    assign bus.line_a     = lineA;
    assign bus.line_b     = lineB;
    assign bus.disp_on    = dispOn_q;
    assign bus.ddram_addr = addr_q;
    assign bus.busy       = (busyCnt_q != 16'd0);
    assign bus.wr_strobe  = wrStrobe_q;
    assign bus.cmd_err    = cmdErr_q;
    assign bus.timing_err = timingErr_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: directed scenarios plus randomized bus traffic
// checked against an address-ring model of the 2x40 display memory.
module tb_lcd_bus_responder;
    localparam int INS_BUSY   = 10;
    localparam int DATA_BUSY  = 10;
    localparam int CLEAR_BUSY = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_bus_responder_if bus ();

    lcd_bus_responder #(
        .INS_BUSY(INS_BUSY), .DATA_BUSY(DATA_BUSY), .CLEAR_BUSY(CLEAR_BUSY), .E_MIN_HIGH(2)
    ) dut (
        .mclk(clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: memory indexed directly by DDRAM address.
    logic [7:0] mdd [0:127];
    int         mAddr;
    bit         mInc, mDisp, mCgram;
    logic [127:0] spaces;

    task automatic modelReset();
        for (int i = 0; i < 128; i++) mdd[i] = 8'h20;
        mAddr = 0; mInc = 1; mDisp = 0; mCgram = 0;
    endtask

    function automatic int movePos(input int a, input int dir);
        int pos;
        pos = (a >= 64) ? 40 + a - 64 : a;
        pos = (pos + dir + 80) % 80;
        return (pos >= 40) ? 64 + pos - 40 : pos;
    endfunction

    function automatic logic [127:0] expLine(input int base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = mdd[base + i];
        return v;
    endfunction

    task automatic modelApply(input bit rs, input bit rw, input logic [7:0] d,
                              output int eWr, output int eCmd, output int eBusy);
        int a;
        eWr = 0; eCmd = 0; eBusy = 0;
        a = int'(d[6:0]);
        if (rw) begin
            eCmd = 1;
        end else if (rs) begin
            eWr = 1;
            eBusy = DATA_BUSY;
            if (!mCgram) begin
                mdd[mAddr] = d;
                mAddr = movePos(mAddr, mInc ? 1 : -1);
            end
        end else begin
            eBusy = INS_BUSY;
            if (d >= 8'h80) begin
                mCgram = 0;
                if (a < 40 || (a >= 64 && a < 104)) mAddr = a; else eCmd = 1;
            end else if (d >= 8'h40) mCgram = 1;
            else if (d >= 8'h20) begin
                if (d < 8'h30) eCmd = 1;
            end else if (d >= 8'h10) begin
                if (d < 8'h18) mAddr = movePos(mAddr, (d >= 8'h14) ? 1 : -1);
            end else if (d >= 8'h08) mDisp = (d[2] == 1'b1);
            else if (d >= 8'h04) mInc = (d[1] == 1'b1);
            else if (d >= 8'h02) begin
                mAddr = 0; eBusy = CLEAR_BUSY;
            end else if (d == 8'h01) begin
                for (int i = 0; i < 128; i++) mdd[i] = 8'h20;
                mAddr = 0; mInc = 1; eBusy = CLEAR_BUSY;
            end
        end
    endtask

    // One E strobe held for 'hi' cycles; gathers pulses and busy cycles until idle again.
    task automatic applyStimulus(input bit rs, input bit rw, input logic [7:0] d, input int hi,
                                 input bit waitBusy, output int wr, output int ce, output int te,
                                 output int bc);
        int guard;
        wr = 0; ce = 0; te = 0; bc = 0;
        @(negedge clk);
        bus.DB = d; bus.RS = rs; bus.RW = rw; bus.E = 1'b1;
        repeat (hi) @(negedge clk);
        bus.E = 1'b0;
        bus.DB = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.wr_strobe) wr++;
            if (bus.cmd_err) ce++;
            if (bus.timing_err) te++;
            if (bus.busy) bc++;
        end
        if (waitBusy) begin
            guard = 0;
            while (bus.busy === 1'b1 && guard < 400) begin
                @(negedge clk);
                if (bus.busy) bc++;
                guard++;
            end
            checks++;
            if (bus.busy !== 1'b0) $display("[TB] FAIL busy_timeout got=%b exp=0", bus.busy);
            else passes++;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.E = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.DB = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        int wr = 0, ev = 0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.wr_strobe) wr++;
            if (bus.cmd_err || bus.timing_err) ev++;
        end
        checks++; if (bus.line_a !== spaces) $display("[TB] FAIL reset_line_a got=%h exp=%h", bus.line_a, spaces); else passes++;
        checks++; if (bus.line_b !== spaces) $display("[TB] FAIL reset_line_b got=%h exp=%h", bus.line_b, spaces); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); else passes++;
        checks++; if (bus.ddram_addr !== 7'h00) $display("[TB] FAIL reset_addr got=%h exp=00", bus.ddram_addr); else passes++;
        checks++; if (bus.disp_on !== 1'b0) $display("[TB] FAIL reset_disp_on got=%b exp=0", bus.disp_on); else passes++;
        checks++; if (wr + ev !== 0) $display("[TB] FAIL reset_pulses got=%0d exp=0", wr + ev); else passes++;
    endtask

    task automatic test_init_mon();
        logic [7:0] seq [7] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h4D, 8'h6F, 8'h6E};
        int wr, ce, te, bc, eWr, eCmd, eBusy, totWr;
        bit rs;
        totWr = 0;
        for (int i = 0; i < 7; i++) begin
            rs = (i >= 4);
            applyStimulus(rs, 1'b0, seq[i], 2, 1'b1, wr, ce, te, bc);
            modelApply(rs, 1'b0, seq[i], eWr, eCmd, eBusy);
            totWr += wr;
            checks++; if (bc !== eBusy) $display("[TB] FAIL init_busy_cycles[%0d] got=%0d exp=%0d", i, bc, eBusy); else passes++;
        end
        checks++; if (totWr !== 3) $display("[TB] FAIL init_wr_strobes got=%0d exp=3", totWr); else passes++;
        checks++; if (bus.line_a[23:0] !== 24'h6E6F4D) $display("[TB] FAIL init_mon got=%h exp=6e6f4d", bus.line_a[23:0]); else passes++;
        checks++; if (bus.disp_on !== 1'b1) $display("[TB] FAIL init_disp_on got=%b exp=1", bus.disp_on); else passes++;
        checks++; if (bus.ddram_addr !== 7'h03) $display("[TB] FAIL init_addr got=%h exp=03", bus.ddram_addr); else passes++;
        checks++; if (bus.line_a !== expLine(0)) $display("[TB] FAIL init_line_a got=%h exp=%h", bus.line_a, expLine(0)); else passes++;
    endtask

    task automatic test_line_b();
        int wr, ce, te, bc, eWr, eCmd, eBusy;
        applyStimulus(1'b0, 1'b0, 8'hC0, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b0, 1'b0, 8'hC0, eWr, eCmd, eBusy);
        applyStimulus(1'b1, 1'b0, 8'h31, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b1, 1'b0, 8'h31, eWr, eCmd, eBusy);
        checks++; if (bus.line_b[7:0] !== 8'h31) $display("[TB] FAIL lineb_char got=%h exp=31", bus.line_b[7:0]); else passes++;
        checks++; if (bus.ddram_addr !== 7'h41) $display("[TB] FAIL lineb_addr got=%h exp=41", bus.ddram_addr); else passes++;
        checks++; if (bus.line_b !== expLine(64)) $display("[TB] FAIL lineb_full got=%h exp=%h", bus.line_b, expLine(64)); else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] seq [6] = '{8'hA7, 8'h61, 8'h62, 8'hE7, 8'h63, 8'h64};
        int wr, ce, te, bc, eWr, eCmd, eBusy;
        bit rs;
        for (int i = 0; i < 6; i++) begin
            rs = (i % 3 != 0);
            applyStimulus(rs, 1'b0, seq[i], 2, 1'b1, wr, ce, te, bc);
            modelApply(rs, 1'b0, seq[i], eWr, eCmd, eBusy);
            if (i == 2) begin
                checks++; if (bus.line_b[7:0] !== 8'h62) $display("[TB] FAIL wrap27_char got=%h exp=62", bus.line_b[7:0]); else passes++;
                checks++; if (bus.ddram_addr !== 7'h41) $display("[TB] FAIL wrap27_addr got=%h exp=41", bus.ddram_addr); else passes++;
            end
        end
        checks++; if (bus.line_a[7:0] !== 8'h64) $display("[TB] FAIL wrap67_char got=%h exp=64", bus.line_a[7:0]); else passes++;
        checks++; if (bus.ddram_addr !== 7'h01) $display("[TB] FAIL wrap67_addr got=%h exp=01", bus.ddram_addr); else passes++;
        checks++; if (bus.line_a !== expLine(0)) $display("[TB] FAIL wrap_line_a got=%h exp=%h", bus.line_a, expLine(0)); else passes++;
    endtask

    task automatic test_timing();
        int wr, ce, te, bc, eWr, eCmd, eBusy;
        applyStimulus(1'b1, 1'b0, 8'h58, 1, 1'b1, wr, ce, te, bc);
        checks++; if (te !== 1) $display("[TB] FAIL short_e_terr got=%0d exp=1", te); else passes++;
        checks++; if (wr !== 0) $display("[TB] FAIL short_e_wr got=%0d exp=0", wr); else passes++;
        checks++; if (bus.line_a !== expLine(0)) $display("[TB] FAIL short_e_line_a got=%h exp=%h", bus.line_a, expLine(0)); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h01, 2, 1'b0, wr, ce, te, bc);
        modelApply(1'b0, 1'b0, 8'h01, eWr, eCmd, eBusy);
        applyStimulus(1'b1, 1'b0, 8'h41, 2, 1'b1, wr, ce, te, bc);
        checks++; if (te !== 1) $display("[TB] FAIL busy_rise_terr got=%0d exp=1", te); else passes++;
        checks++; if (wr !== 0) $display("[TB] FAIL busy_rise_wr got=%0d exp=0", wr); else passes++;
        checks++; if (bus.line_a !== expLine(0)) $display("[TB] FAIL busy_rise_line_a got=%h exp=%h", bus.line_a, expLine(0)); else passes++;
        checks++; if (bus.line_b !== expLine(64)) $display("[TB] FAIL clear_line_b got=%h exp=%h", bus.line_b, expLine(64)); else passes++;
        applyStimulus(1'b1, 1'b0, 8'h41, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b1, 1'b0, 8'h41, eWr, eCmd, eBusy);
        checks++; if (bus.line_a[7:0] !== 8'h41 || wr !== 1) $display("[TB] FAIL after_reject_write got=%h/%0d exp=41/1", bus.line_a[7:0], wr); else passes++;
    endtask

    task automatic test_errors();
        int wr, ce, te, bc, eWr, eCmd, eBusy, wrSum;
        applyStimulus(1'b0, 1'b1, 8'h00, 2, 1'b1, wr, ce, te, bc);
        checks++; if (ce !== 1 || bc !== 0) $display("[TB] FAIL read_cmd_err got=%0d/%0d exp=1/0", ce, bc); else passes++;
        applyStimulus(1'b0, 1'b0, 8'hB0, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b0, 1'b0, 8'hB0, eWr, eCmd, eBusy);
        checks++; if (ce !== 1) $display("[TB] FAIL bad_addr_cmd_err got=%0d exp=1", ce); else passes++;
        checks++; if (bus.ddram_addr !== 7'(mAddr)) $display("[TB] FAIL bad_addr_kept got=%h exp=%h", bus.ddram_addr, 7'(mAddr)); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h28, 2, 1'b1, wr, ce, te, bc);
        checks++; if (ce !== 1) $display("[TB] FAIL dl0_cmd_err got=%0d exp=1", ce); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h38, 2, 1'b1, wr, ce, te, bc);
        checks++; if (ce !== 0) $display("[TB] FAIL dl1_cmd_err got=%0d exp=0", ce); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h40, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b0, 1'b0, 8'h40, eWr, eCmd, eBusy);
        applyStimulus(1'b1, 1'b0, 8'h7A, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b1, 1'b0, 8'h7A, eWr, eCmd, eBusy);
        checks++; if (wr !== 1 || bus.line_a !== expLine(0)) $display("[TB] FAIL cgram_discard got=%0d/%h exp=1/%h", wr, bus.line_a, expLine(0)); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h80, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b0, 1'b0, 8'h80, eWr, eCmd, eBusy);
        applyStimulus(1'b1, 1'b0, 8'h7A, 2, 1'b1, wr, ce, te, bc);
        modelApply(1'b1, 1'b0, 8'h7A, eWr, eCmd, eBusy);
        checks++; if (bus.line_a[7:0] !== 8'h7A) $display("[TB] FAIL ddram_resume got=%h exp=7a", bus.line_a[7:0]); else passes++;
        wrSum = 0;
        @(negedge clk);
        bus.DB = 8'h5A; bus.RS = 1'b1; bus.RW = 1'b0; bus.E = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.E = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.wr_strobe) wrSum++;
        end
        checks++; if (bus.line_a !== spaces) $display("[TB] FAIL rst_mid_line_a got=%h exp=%h", bus.line_a, spaces); else passes++;
        checks++; if (wrSum !== 0 || bus.ddram_addr !== 7'h00) $display("[TB] FAIL rst_mid_commit got=%0d/%h exp=0/00", wrSum, bus.ddram_addr); else passes++;
    endtask

    task automatic test_random();
        int wr, ce, te, bc, eWr, eCmd, eBusy, pick;
        bit rs, rw;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 11));
            rs = 1'b0; rw = 1'b0;
            case (pick)
                0, 1, 2, 3: begin rs = 1'b1; d = 8'($urandom_range(32, 126)); end
                4:  d = 8'h80 | 8'($urandom_range(0, 127));
                5:  d = 8'h10 | 8'(4 * $urandom_range(0, 3));
                6:  d = 8'h04 | 8'(2 * $urandom_range(0, 1));
                7:  d = 8'h08 | 8'(4 * $urandom_range(0, 1));
                8:  d = ($urandom_range(0, 1) == 0) ? 8'h38 : 8'h28;
                9:  d = 8'($urandom_range(0, 3)) & 8'h02;
                10: begin rw = 1'b1; rs = 1'($urandom_range(0, 1)); d = 8'($urandom); end
                default: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h03;
            endcase
            applyStimulus(rs, rw, d, int'($urandom_range(2, 4)), 1'b1, wr, ce, te, bc);
            modelApply(rs, rw, d, eWr, eCmd, eBusy);
            checks++;
            if (wr !== eWr || ce !== eCmd || te !== 0 || bc !== eBusy)
                $display("[TB] FAIL rand_pulses[%0d] d=%h got=%0d/%0d/%0d/%0d exp=%0d/%0d/0/%0d", n, d, wr, ce, te, bc, eWr, eCmd, eBusy);
            else passes++;
            checks++;
            if (bus.line_a !== expLine(0) || bus.line_b !== expLine(64))
                $display("[TB] FAIL rand_lines[%0d] got=%h/%h exp=%h/%h", n, bus.line_a, bus.line_b, expLine(0), expLine(64));
            else passes++;
            checks++;
            if (bus.ddram_addr !== 7'(mAddr) || bus.disp_on !== mDisp)
                $display("[TB] FAIL rand_state[%0d] got=%h/%b exp=%h/%b", n, bus.ddram_addr, bus.disp_on, 7'(mAddr), mDisp);
            else passes++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        spaces = {16{8'h20}};
        test_reset();
        test_init_mon();
        test_line_b();
        test_wrap();
        test_timing();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
